// File: rtl/product_accumulator_8.sv
// product_accumulator_8: sums ACC_LEN accepted 16-bit products into one result; define PRODUCT_ACC_SATURATE_EN to clamp on carry instead of wrapping
module product_accumulator_8 #(
  parameter int ACC_LEN = 8,
  parameter int ACC_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      product,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       count,
  output logic             overflow
);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, result_q, result_d, acc_sum;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_w;
  logic             carry;
  assign sum_w = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, product};
  assign carry = sum_w[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
  assign acc_sum = carry ? '1 : sum_w[ACC_W-1:0];
`else
  assign acc_sum = sum_w[ACC_W-1:0];
`endif
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  // next state: clear beats accept and release; the last accept latches the result
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear || (state_q == DONE && out_ready)) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ACCUM && in_valid) begin
      acc_d   = acc_sum;
      count_d = count_q + 8'd1;
      ovf_d   = ovf_q | carry;
      if (count_q == 8'(ACC_LEN - 1)) begin
        result_d = acc_sum;
        state_d  = DONE;
      end
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule
